// File: rtl/multicycle_control.sv
// ---------------------------------------------------------------------------
// multicycle_control
//   Moore control sequencer for a multi-cycle MIPS datapath with a single
//   memory port, a shared ALU, the register file and the PC. Each instruction
//   steps through fetch / decode / execute / memory / write-back states.
//   Memory states wait on mem_ready. The block also counts retired
//   instructions and keeps a sticky flag for unsupported opcodes.
//
// Ports
//   clk, reset          rising-edge clock, async active-high reset
//   opcode[5:0]         instruct[31:26]; only looked at in DECODE
//   mem_ready           memory access completes this cycle
//   pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
//   mem_to_reg, reg_dest, reg_write, alu_src_a, alu_src_b[1:0],
//   alu_op[1:0], pc_source[1:0]   datapath controls
//   illegal_op          sticky, unsupported opcode seen in DECODE
//   retired[CNT_W-1:0]  completed instructions, wraps
//   state[STATE_W-1:0]  current state (debug)
// ---------------------------------------------------------------------------
module multicycle_control #(
    parameter int CNT_W   = 32,
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         opcode,
    input  logic               mem_ready,
    output logic               pc_write,
    output logic               pc_write_cond,
    output logic               i_or_d,
    output logic               mem_read,
    output logic               mem_write,
    output logic               ir_write,
    output logic               mem_to_reg,
    output logic               reg_dest,
    output logic               reg_write,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [1:0]         alu_op,
    output logic [1:0]         pc_source,
    output logic               illegal_op,
    output logic [CNT_W-1:0]   retired,
    output logic [STATE_W-1:0] state
);

    typedef enum logic [3:0] {
        FETCH     = 4'd0,
        DECODE    = 4'd1,
        MEM_ADDR  = 4'd2,
        MEM_RD    = 4'd3,
        MEM_WB    = 4'd4,
        MEM_WR    = 4'd5,
        EXEC      = 4'd6,
        R_WB      = 4'd7,
        BRANCH    = 4'd8,
        JUMP      = 4'd9,
        ADDI_EXEC = 4'd10,
        ADDI_WB   = 4'd11
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;

    state_t             state_q, state_d;
    logic               is_sw_q, is_sw_d;   // lw/sw choice latched in DECODE
    logic               illegal_q, illegal_d;
    logic [CNT_W-1:0]   retired_q, retired_d;

    always_comb begin
        state_d   = state_q;
        is_sw_d   = is_sw_q;
        illegal_d = illegal_q;
        retired_d = retired_q;
        case (state_q)
            FETCH:     if (mem_ready) state_d = DECODE;
            DECODE: begin
                is_sw_d = (opcode == OP_SW);
                case (opcode)
                    OP_LW, OP_SW: state_d = MEM_ADDR;
                    OP_R:         state_d = EXEC;
                    OP_BEQ:       state_d = BRANCH;
                    OP_J:         state_d = JUMP;
                    OP_ADDI:      state_d = ADDI_EXEC;
                    default: begin
                        state_d   = FETCH;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            MEM_ADDR:  state_d = is_sw_q ? MEM_WR : MEM_RD;
            MEM_RD:    if (mem_ready) state_d = MEM_WB;
            MEM_WR: begin
                if (mem_ready) begin
                    state_d   = FETCH;
                    retired_d = retired_q + CNT_W'(1);
                end
            end
            EXEC:      state_d = R_WB;
            ADDI_EXEC: state_d = ADDI_WB;
            MEM_WB, R_WB, BRANCH, JUMP, ADDI_WB: begin
                state_d   = FETCH;
                retired_d = retired_q + CNT_W'(1);
            end
            default:   state_d = FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= FETCH;
            is_sw_q   <= 1'b0;
            illegal_q <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            is_sw_q   <= is_sw_d;
            illegal_q <= illegal_d;
            retired_q <= retired_d;
        end
    end

    // Moore decode of the state register. Gated by reset so enables drop in
    // the same cycle reset rises, before the register has been cleared.
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dest      = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        pc_source     = 2'b00;
        if (!reset) begin
            case (state_q)
                FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = 2'b01;
                    // IR and PC load only on the cycle the fetch completes
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                end
                DECODE:    alu_src_b = 2'b11;
                MEM_ADDR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                end
                MEM_RD: begin
                    mem_read = 1'b1;
                    i_or_d   = 1'b1;
                end
                MEM_WB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                end
                MEM_WR: begin
                    mem_write = 1'b1;
                    i_or_d    = 1'b1;
                end
                EXEC: begin
                    alu_src_a = 1'b1;
                    alu_op    = 2'b10;
                end
                R_WB: begin
                    reg_write = 1'b1;
                    reg_dest  = 1'b1;
                end
                BRANCH: begin
                    alu_src_a     = 1'b1;
                    alu_op        = 2'b01;
                    pc_write_cond = 1'b1;
                    pc_source     = 2'b01;
                end
                JUMP: begin
                    pc_write  = 1'b1;
                    pc_source = 2'b10;
                end
                ADDI_EXEC: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                end
                ADDI_WB:   reg_write = 1'b1;
                default: ;
            endcase
        end
    end

    assign illegal_op = illegal_q;
    assign retired    = retired_q;
    assign state      = STATE_W'(state_q);

endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;

    logic clk = 1'b0;
    logic reset;
    logic [5:0] opcode, opcode2;
    logic mem_ready, mem_ready2;

    logic pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic mem_to_reg, reg_dest, reg_write, alu_src_a;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic illegal_op;
    logic [31:0] retired;
    logic [3:0] state;

    logic pc_write2, pc_write_cond2, i_or_d2, mem_read2, mem_write2, ir_write2;
    logic mem_to_reg2, reg_dest2, reg_write2, alu_src_a2;
    logic [1:0] alu_src_b2, alu_op2, pc_source2;
    logic illegal_op2;
    logic [1:0] retired2;
    logic [3:0] state2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    multicycle_control #(.CNT_W(32), .STATE_W(4)) u_dut (
        .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .mem_to_reg(mem_to_reg), .reg_dest(reg_dest), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .pc_source(pc_source), .illegal_op(illegal_op), .retired(retired),
        .state(state)
    );

    multicycle_control #(.CNT_W(2), .STATE_W(4)) u_dut2 (
        .clk(clk), .reset(reset), .opcode(opcode2), .mem_ready(mem_ready2),
        .pc_write(pc_write2), .pc_write_cond(pc_write_cond2), .i_or_d(i_or_d2),
        .mem_read(mem_read2), .mem_write(mem_write2), .ir_write(ir_write2),
        .mem_to_reg(mem_to_reg2), .reg_dest(reg_dest2), .reg_write(reg_write2),
        .alu_src_a(alu_src_a2), .alu_src_b(alu_src_b2), .alu_op(alu_op2),
        .pc_source(pc_source2), .illegal_op(illegal_op2), .retired(retired2),
        .state(state2)
    );

    // {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
    //  mem_to_reg, reg_dest, reg_write, alu_src_a, alu_src_b, alu_op, pc_source}
    logic [15:0] ctl, ctl2;
    assign ctl  = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                   mem_to_reg, reg_dest, reg_write, alu_src_a, alu_src_b, alu_op, pc_source};
    assign ctl2 = {pc_write2, pc_write_cond2, i_or_d2, mem_read2, mem_write2, ir_write2,
                   mem_to_reg2, reg_dest2, reg_write2, alu_src_a2, alu_src_b2, alu_op2, pc_source2};

    localparam logic [5:0] LW = 6'h23, SW = 6'h2B, RT = 6'h00, BEQ = 6'h04,
                           JMP = 6'h02, ADDI = 6'h08, XX = 6'h3F;

    // Expected control word for a state, taken from the state table.
    function automatic logic [15:0] ctl_of(input logic [3:0] st, input logic rdy);
        logic [15:0] c;
        c = '0;
        case (st)
            4'd0:  begin c[12] = 1'b1; c[5:4] = 2'b01; c[15] = rdy; c[10] = rdy; end
            4'd1:  c[5:4] = 2'b11;
            4'd2:  begin c[6] = 1'b1; c[5:4] = 2'b10; end
            4'd3:  begin c[12] = 1'b1; c[13] = 1'b1; end
            4'd4:  begin c[7] = 1'b1; c[9] = 1'b1; end
            4'd5:  begin c[11] = 1'b1; c[13] = 1'b1; end
            4'd6:  begin c[6] = 1'b1; c[3:2] = 2'b10; end
            4'd7:  begin c[7] = 1'b1; c[8] = 1'b1; end
            4'd8:  begin c[6] = 1'b1; c[3:2] = 2'b01; c[14] = 1'b1; c[1:0] = 2'b01; end
            4'd9:  begin c[15] = 1'b1; c[1:0] = 2'b10; end
            4'd10: begin c[6] = 1'b1; c[5:4] = 2'b10; end
            4'd11: c[7] = 1'b1;
            default: c = '0;
        endcase
        return c;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [5:0]  op;
        logic        rdy;
        logic [3:0]  st;
        logic [31:0] ret;
        logic        ill;
    } vec_t;

    typedef struct {
        logic [3:0]  st;
        logic [15:0] c;
        logic [31:0] ret;
        logic        ill;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    function automatic vec_t mk(logic [5:0] op, logic rdy, logic [3:0] st,
                                logic [31:0] ret, logic ill);
        vec_t v;
        v.op = op; v.rdy = rdy; v.st = st; v.ret = ret; v.ill = ill;
        return v;
    endfunction

    initial begin
        exp_t e;
        logic [1:0] wrap_exp [5];

        // lw, mem_ready always 1: states 0,1,2,3,4
        vecs.push_back(mk(LW, 1, 0, 0, 0));  vecs.push_back(mk(LW, 1, 1, 0, 0));
        vecs.push_back(mk(XX, 1, 2, 0, 0));  vecs.push_back(mk(XX, 1, 3, 0, 0));
        vecs.push_back(mk(XX, 1, 4, 0, 0));
        // sw with three stall cycles in MEM_WR
        vecs.push_back(mk(SW, 1, 0, 1, 0));  vecs.push_back(mk(SW, 1, 1, 1, 0));
        vecs.push_back(mk(XX, 1, 2, 1, 0));  vecs.push_back(mk(XX, 0, 5, 1, 0));
        vecs.push_back(mk(XX, 0, 5, 1, 0));  vecs.push_back(mk(XX, 0, 5, 1, 0));
        vecs.push_back(mk(XX, 1, 5, 1, 0));
        // R-type (mem_ready low in non-memory states has no effect)
        vecs.push_back(mk(RT, 1, 0, 2, 0));  vecs.push_back(mk(RT, 0, 1, 2, 0));
        vecs.push_back(mk(XX, 0, 6, 2, 0));  vecs.push_back(mk(XX, 1, 7, 2, 0));
        // beq, j
        vecs.push_back(mk(BEQ, 1, 0, 3, 0)); vecs.push_back(mk(BEQ, 1, 1, 3, 0));
        vecs.push_back(mk(XX, 1, 8, 3, 0));
        vecs.push_back(mk(JMP, 1, 0, 4, 0)); vecs.push_back(mk(JMP, 1, 1, 4, 0));
        vecs.push_back(mk(XX, 0, 9, 4, 0));
        // addi
        vecs.push_back(mk(ADDI, 1, 0, 5, 0)); vecs.push_back(mk(ADDI, 1, 1, 5, 0));
        vecs.push_back(mk(XX, 1, 10, 5, 0)); vecs.push_back(mk(XX, 0, 11, 5, 0));
        // illegal opcode, then lw with a fetch stall and a MEM_RD stall
        vecs.push_back(mk(XX, 1, 0, 6, 0));  vecs.push_back(mk(XX, 1, 1, 6, 0));
        vecs.push_back(mk(LW, 0, 0, 6, 1));  vecs.push_back(mk(LW, 1, 0, 6, 1));
        vecs.push_back(mk(LW, 1, 1, 6, 1));  vecs.push_back(mk(XX, 1, 2, 6, 1));
        vecs.push_back(mk(XX, 0, 3, 6, 1));  vecs.push_back(mk(XX, 1, 3, 6, 1));
        vecs.push_back(mk(XX, 1, 4, 6, 1));  vecs.push_back(mk(XX, 0, 0, 7, 1));

        wrap_exp[0] = 2'd1; wrap_exp[1] = 2'd2; wrap_exp[2] = 2'd3;
        wrap_exp[3] = 2'd0; wrap_exp[4] = 2'd1;

        reset = 1'b1; opcode = RT; mem_ready = 1'b1; opcode2 = RT; mem_ready2 = 1'b0;
        @(negedge clk);
        #1;
        chk("reset_state",   32'(state),   0);
        chk("reset_ctl",     32'(ctl),     0);
        chk("reset_retired", retired,      0);
        chk("reset_illegal", 32'(illegal_op), 0);

        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < vecs.size(); i++) begin
            opcode    = vecs[i].op;
            mem_ready = vecs[i].rdy;
            e.st = vecs[i].st; e.c = ctl_of(vecs[i].st, vecs[i].rdy);
            e.ret = vecs[i].ret; e.ill = vecs[i].ill;
            sb.push_back(e);
            #1;
            e = sb.pop_front();
            chk($sformatf("v%0d_state", i),   32'(state),      32'(e.st));
            chk($sformatf("v%0d_ctl", i),     32'(ctl),        32'(e.c));
            chk($sformatf("v%0d_retired", i), retired,         e.ret);
            chk($sformatf("v%0d_illegal", i), 32'(illegal_op), 32'(e.ill));
            @(negedge clk);
        end

        // Reset mid-cycle while stalled in MEM_RD
        opcode = LW; mem_ready = 1'b1;
        repeat (3) @(negedge clk);
        opcode = XX; mem_ready = 1'b0;
        #2;
        chk("pre_reset_state", 32'(state), 3);
        reset = 1'b1; mem_ready = 1'b1;
        #1;
        chk("midrst_state",   32'(state),      0);
        chk("midrst_ctl",     32'(ctl),        0);
        chk("midrst_retired", retired,         0);
        chk("midrst_illegal", 32'(illegal_op), 0);
        @(negedge clk);
        reset = 1'b0; opcode = RT;
        #1;
        chk("post_rst_ctl", 32'(ctl), 32'(ctl_of(0, 1)));
        @(negedge clk);
        #1;
        chk("post_rst_decode", 32'(state), 1);
        chk("post_rst_retired", retired, 0);

        // Narrow counter wraps: five R-type instructions
        mem_ready2 = 1'b1; opcode2 = RT;
        for (int k = 0; k < 5; k++) begin
            repeat (4) @(negedge clk);
            #1;
            chk($sformatf("wrap%0d_retired", k), 32'(retired2), 32'(wrap_exp[k]));
            chk($sformatf("wrap%0d_state", k),   32'(state2),   0);
            chk($sformatf("wrap%0d_ctl", k),     32'(ctl2),     32'(ctl_of(0, 1)));
            chk($sformatf("wrap%0d_illegal", k), 32'(illegal_op2), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
